share_zero_stream: RTL and testbench

Streaming, parametrised generator of fresh Boolean sharings of zero for masked AES datapaths. Takes uniform randomness from the upstream PRNG over a valid/ready handshake, builds one zero-sharing per channel for 2 to 8 shares, and buffers results in a shift-register FIFO. The output is driven directly from flops, so no share mixing occurs. It replaces fixed, always-consume zero-sharing stages wherever refresh randomness is delivered in bursts or consumed irregularly.

---
 rtl/aes128_package.sv | 21 ++
 rtl/zero_sharing_comb.sv | 42 ++++
 rtl/share_zero_stream.sv | 127 ++++++++++++
 tb/tb_share_zero_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_package.sv
// Shared definitions for the masked AES datapath.
// num_share_0 returns how many fresh random words a zero-sharing of n shares
// consumes: one for two shares, two for three shares, n (ring) for four and up.
package aes128_package;

  localparam int unsigned MIN_SHARES     = 2;
  localparam int unsigned MAX_SHARES     = 8;
  localparam int unsigned MIN_FIFO_DEPTH = 1;
  localparam int unsigned MAX_FIFO_DEPTH = 16;

  function automatic int unsigned num_share_0(input int unsigned n);
    if (n == 2) begin
      return 1;
    end else if (n == 3) begin
      return 2;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/zero_sharing_comb.sv
// Combinational zero-sharing of one channel.
// Ports:
//   random  : NUM_NEEDED words of BIT_WIDTH bits, word i at [i*BIT_WIDTH +: BIT_WIDTH]
//   sharing : NUM_SHARES shares of BIT_WIDTH bits, share i at [i*BIT_WIDTH +: BIT_WIDTH];
//             the XOR of all shares is zero.
module zero_sharing_comb
  import aes128_package::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned BIT_WIDTH  = 2
) (
  input  logic [num_share_0(NUM_SHARES)*BIT_WIDTH-1:0] random,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]              sharing
);

  typedef logic [BIT_WIDTH-1:0] share_t;

  if (NUM_SHARES == 2) begin : g_two
    always_comb begin
      sharing = {random, random};
    end
  end else if (NUM_SHARES == 3) begin : g_three
    share_t r0;
    share_t r1;
    always_comb begin
      r0      = random[0 +: BIT_WIDTH];
      r1      = random[BIT_WIDTH +: BIT_WIDTH];
      sharing = {r0 ^ r1, r1, r0};
    end
  end else begin : g_ring
    // Each word feeds exactly two neighbouring shares, so the ring XORs to zero.
    always_comb begin
      sharing = '0;
      for (int unsigned i = 0; i < NUM_SHARES; i++) begin
        sharing[i*BIT_WIDTH +: BIT_WIDTH] =
          share_t'(random[i*BIT_WIDTH +: BIT_WIDTH] ^
                   random[((i + 1) % NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/share_zero_stream.sv
// Streaming generator of fresh Boolean zero-sharings with a shift-register FIFO.
// Ports:
//   in_clock, in_reset : clock (rising edge), synchronous active-high reset
//   in_random/in_valid/out_in_ready : randomness input handshake
//   in_flush           : discard all buffered sharings
//   out_random/out_valid/in_ready   : head sharing output handshake
//   out_level          : number of buffered sharings
// Slot 0 is the head and drives out_random straight from its flops.
module share_zero_stream
  import aes128_package::*;
#(
  parameter int unsigned NUM_SHARES   = 2,
  parameter int unsigned BIT_WIDTH    = 2,
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                                                   in_clock,
  input  logic                                                   in_reset,
  input  logic [NUM_CHANNELS*num_share_0(NUM_SHARES)*BIT_WIDTH-1:0] in_random,
  input  logic                                                   in_valid,
  output logic                                                   out_in_ready,
  input  logic                                                   in_flush,
  output logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]           out_random,
  output logic                                                   out_valid,
  input  logic                                                   in_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]                        out_level
);

  localparam int unsigned NUM_NEEDED = num_share_0(NUM_SHARES);
  localparam int unsigned IN_CH_W    = NUM_NEEDED * BIT_WIDTH;
  localparam int unsigned OUT_CH_W   = NUM_SHARES * BIT_WIDTH;
  localparam int unsigned SHARING_W  = NUM_CHANNELS * OUT_CH_W;
  localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [LEVEL_W-1:0] DEPTH_LVL = LEVEL_W'(FIFO_DEPTH);

  if (NUM_SHARES < MIN_SHARES || NUM_SHARES > MAX_SHARES) begin : g_bad_shares
    $error("share_zero_stream: NUM_SHARES must be in 2..8");
  end
  if (FIFO_DEPTH < MIN_FIFO_DEPTH || FIFO_DEPTH > MAX_FIFO_DEPTH) begin : g_bad_depth
    $error("share_zero_stream: FIFO_DEPTH must be in 1..16");
  end

  logic [SHARING_W-1:0] new_sharing;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
    zero_sharing_comb #(
      .NUM_SHARES (NUM_SHARES),
      .BIT_WIDTH  (BIT_WIDTH)
    ) u_zero_sharing (
      .random  (in_random[c*IN_CH_W +: IN_CH_W]),
      .sharing (new_sharing[c*OUT_CH_W +: OUT_CH_W])
    );
  end

  logic [SHARING_W-1:0] slot_q [FIFO_DEPTH];
  logic [SHARING_W-1:0] slot_d [FIFO_DEPTH];
  logic [LEVEL_W-1:0]   level_q;
  logic [LEVEL_W-1:0]   level_d;
  logic [LEVEL_W-1:0]   wr_idx;
  logic                 can_push;
  logic                 push;
  logic                 pop;

  // No pass-through when full: readiness depends on the registered level only.
  always_comb begin
    can_push = (level_q < DEPTH_LVL);
    push     = in_valid && can_push;
    pop      = (level_q != '0) && in_ready;
    wr_idx   = pop ? (level_q - 1'b1) : level_q;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // Shift first, then overlay the write: a same-cycle push lands one slot lower.
  always_comb begin
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (pop) begin
      for (int unsigned k = 0; k + 1 < FIFO_DEPTH; k++) begin
        slot_d[k] = slot_q[k+1];
      end
      slot_d[FIFO_DEPTH-1] = '0;
    end
    if (push) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        if (wr_idx == LEVEL_W'(k)) begin
          slot_d[k] = new_sharing;
        end
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset || in_flush) begin
      level_q <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    out_random   = slot_q[0];
    out_valid    = (level_q != '0);
    out_in_ready = can_push;
    out_level    = level_q;
  end

  level_bound_a: assert property (@(posedge in_clock) disable iff (in_reset)
    level_q <= DEPTH_LVL);
  level_underflow_a: assert property (@(posedge in_clock) disable iff (in_reset)
    pop |-> (level_q != '0));

endmodule

// File: tb/tb_share_zero_stream.sv
module tb_share_zero_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // dut2: 2 shares, 2 bits, 1 channel, depth 2
  logic [1:0] r2 = '0;
  logic       v2 = 1'b0, rdy2 = 1'b0, fl2 = 1'b0;
  logic       ordy2, ov2;
  logic [3:0] oran2;
  logic [1:0] lvl2;

  // dut3: 3 shares, 4 bits
  logic [7:0]  r3 = '0;
  logic        v3 = 1'b0;
  logic        ordy3, ov3;
  logic [11:0] oran3;
  logic [1:0]  lvl3;

  // dut4: 4 shares, 8 bits
  logic [31:0] r4 = '0;
  logic        v4 = 1'b0;
  logic        ordy4, ov4;
  logic [31:0] oran4;
  logic [1:0]  lvl4;

  // dut5: 5 shares, 4 bits, 3 channels, depth 4
  logic [59:0] r5 = '0;
  logic        v5 = 1'b0, rdy5 = 1'b0;
  logic        ordy5, ov5;
  logic [59:0] oran5;
  logic [2:0]  lvl5;

  share_zero_stream #(.NUM_SHARES(2), .BIT_WIDTH(2), .NUM_CHANNELS(1), .FIFO_DEPTH(2)) dut2 (
    .in_clock(clk), .in_reset(rst), .in_random(r2), .in_valid(v2), .out_in_ready(ordy2),
    .in_flush(fl2), .out_random(oran2), .out_valid(ov2), .in_ready(rdy2), .out_level(lvl2));

  share_zero_stream #(.NUM_SHARES(3), .BIT_WIDTH(4), .NUM_CHANNELS(1), .FIFO_DEPTH(2)) dut3 (
    .in_clock(clk), .in_reset(rst), .in_random(r3), .in_valid(v3), .out_in_ready(ordy3),
    .in_flush(1'b0), .out_random(oran3), .out_valid(ov3), .in_ready(1'b0), .out_level(lvl3));

  share_zero_stream #(.NUM_SHARES(4), .BIT_WIDTH(8), .NUM_CHANNELS(1), .FIFO_DEPTH(2)) dut4 (
    .in_clock(clk), .in_reset(rst), .in_random(r4), .in_valid(v4), .out_in_ready(ordy4),
    .in_flush(1'b0), .out_random(oran4), .out_valid(ov4), .in_ready(1'b0), .out_level(lvl4));

  share_zero_stream #(.NUM_SHARES(5), .BIT_WIDTH(4), .NUM_CHANNELS(3), .FIFO_DEPTH(4)) dut5 (
    .in_clock(clk), .in_reset(rst), .in_random(r5), .in_valid(v5), .out_in_ready(ordy5),
    .in_flush(1'b0), .out_random(oran5), .out_valid(ov5), .in_ready(rdy5), .out_level(lvl5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] ring5(input logic [59:0] r);
    logic [59:0] s = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 5; i++) begin
        s[(c*5+i)*4 +: 4] = r[(c*5+i)*4 +: 4] ^ r[(c*5+(i+1)%5)*4 +: 4];
      end
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov2); end
    total++; if (oran2 !== 4'h0) begin bad++; $display("FAIL reset_random got=%h want=0", oran2); end
    total++; if (lvl2 !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl2); end
    total++; if (ordy2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ordy2); end
    total++; if (ov5 !== 1'b0 || lvl5 !== 3'd0 || ordy5 !== 1'b1 || oran5 !== 60'h0) begin
      bad++; $display("FAIL reset_dut5 got v=%b l=%0d r=%b d=%h want v=0 l=0 r=1 d=0", ov5, lvl5, ordy5, oran5);
    end
  endtask

  task automatic test_two_shares();
    r2 = 2'b10; v2 = 1'b1; rdy2 = 1'b0;
    tick();
    v2 = 1'b0;
    total++; if (oran2 !== 4'b1010) begin bad++; $display("FAIL n2_random got=%b want=1010", oran2); end
    total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL n2_valid got=%b want=1", ov2); end
    total++; if (lvl2 !== 2'd1) begin bad++; $display("FAIL n2_level got=%0d want=1", lvl2); end
    rdy2 = 1'b1;
    tick();
    rdy2 = 1'b0;
    total++; if (lvl2 !== 2'd0 || ov2 !== 1'b0 || oran2 !== 4'h0) begin
      bad++; $display("FAIL n2_drain got l=%0d v=%b d=%b want l=0 v=0 d=0000", lvl2, ov2, oran2);
    end
  endtask

  task automatic test_three_shares();
    r3 = 8'h53; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    total++; if (oran3 !== 12'h653) begin bad++; $display("FAIL n3_random got=%h want=653", oran3); end
    total++; if (oran3[3:0] ^ oran3[7:4] ^ oran3[11:8]) begin
      bad++; $display("FAIL n3_xor got=%h want=0", oran3[3:0] ^ oran3[7:4] ^ oran3[11:8]);
    end
  endtask

  task automatic test_ring();
    r4 = 32'h08040201; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    total++; if (oran4 !== 32'h090C0603) begin bad++; $display("FAIL n4_random got=%h want=090c0603", oran4); end
    total++; if ((oran4[7:0] ^ oran4[15:8] ^ oran4[23:16] ^ oran4[31:24]) !== 8'h00) begin
      bad++; $display("FAIL n4_xor got=%h want=00", oran4[7:0] ^ oran4[15:8] ^ oran4[23:16] ^ oran4[31:24]);
    end
    total++; if (ov4 !== 1'b1 || lvl4 !== 2'd1) begin
      bad++; $display("FAIL n4_state got v=%b l=%0d want v=1 l=1", ov4, lvl4);
    end
  endtask

  task automatic test_fill();
    rdy2 = 1'b0; v2 = 1'b1;
    r2 = 2'b01; tick();
    total++; if (ordy2 !== 1'b1 || lvl2 !== 2'd1) begin
      bad++; $display("FAIL fill1 got r=%b l=%0d want r=1 l=1", ordy2, lvl2);
    end
    r2 = 2'b10; tick();
    total++; if (ordy2 !== 1'b0 || lvl2 !== 2'd2) begin
      bad++; $display("FAIL fill2 got r=%b l=%0d want r=0 l=2", ordy2, lvl2);
    end
    r2 = 2'b11; tick();
    v2 = 1'b0;
    total++; if (lvl2 !== 2'd2) begin bad++; $display("FAIL fill3_level got=%0d want=2", lvl2); end
    total++; if (oran2 !== 4'b0101) begin bad++; $display("FAIL fill3_head got=%b want=0101", oran2); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] data [4];
    logic [3:0] head [4];
    logic       rdy  [4];
    data = '{2'b11, 2'b11, 2'b01, 2'b10};
    head = '{4'b0101, 4'b1010, 4'b1111, 4'b0101};
    rdy  = '{1'b0, 1'b1, 1'b1, 1'b1};
    v2 = 1'b1; rdy2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r2 = data[i];
      total++; if (ov2 !== 1'b1 || oran2 !== head[i] || ordy2 !== rdy[i]) begin
        bad++; $display("FAIL b2b_%0d got v=%b d=%b r=%b want v=1 d=%b r=%b", i, ov2, oran2, ordy2, head[i], rdy[i]);
      end
      tick();
    end
    v2 = 1'b0; rdy2 = 1'b0;
    total++; if (lvl2 !== 2'd1 || oran2 !== 4'b1010) begin
      bad++; $display("FAIL b2b_end got l=%0d d=%b want l=1 d=1010", lvl2, oran2);
    end
  endtask

  task automatic test_flush();
    r2 = 2'b01; v2 = 1'b1; tick();
    total++; if (lvl2 !== 2'd2) begin bad++; $display("FAIL flush_pre_level got=%0d want=2", lvl2); end
    fl2 = 1'b1; r2 = 2'b11; rdy2 = 1'b1;
    #1;
    total++; if (ordy2 !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", ordy2); end
    tick();
    fl2 = 1'b0; v2 = 1'b0; rdy2 = 1'b0;
    total++; if (lvl2 !== 2'd0 || ov2 !== 1'b0 || oran2 !== 4'h0 || ordy2 !== 1'b1) begin
      bad++; $display("FAIL flush_after got l=%0d v=%b d=%b r=%b want l=0 v=0 d=0000 r=1", lvl2, ov2, oran2, ordy2);
    end
  endtask

  task automatic test_reset_mid();
    r2 = 2'b10; v2 = 1'b1; tick();
    total++; if (lvl2 !== 2'd1) begin bad++; $display("FAIL rstmid_pre got=%0d want=1", lvl2); end
    rst = 1'b1; r2 = 2'b11;
    tick();
    rst = 1'b0; v2 = 1'b0;
    total++; if (ov2 !== 1'b0 || lvl2 !== 2'd0 || oran2 !== 4'h0 || ordy2 !== 1'b1) begin
      bad++; $display("FAIL rstmid_after got v=%b l=%0d d=%b r=%b want v=0 l=0 d=0000 r=1", ov2, lvl2, oran2, ordy2);
    end
  endtask

  task automatic test_random_stream();
    logic [59:0] q [$];
    logic [3:0]  x;
    logic        push, pop;
    int          lvl_m = 0;
    for (int n = 0; n < 1000; n++) begin
      r5   = 60'({$urandom(), $urandom()});
      v5   = ($urandom_range(9, 0) < 7);
      rdy5 = ($urandom_range(1, 0) == 1);
      total++; if (lvl5 !== 3'(lvl_m) || ov5 !== (lvl_m != 0) || ordy5 !== (lvl_m < 4)) begin
        bad++; $display("FAIL rnd_ctrl_%0d got l=%0d v=%b r=%b want l=%0d", n, lvl5, ov5, ordy5, lvl_m);
      end
      push = v5 && (lvl_m < 4);
      pop  = rdy5 && (lvl_m != 0);
      if (pop) begin
        total++; if (oran5 !== q[0]) begin
          bad++; $display("FAIL rnd_data_%0d got=%h want=%h", n, oran5, q[0]);
        end
        for (int c = 0; c < 3; c++) begin
          x = '0;
          for (int i = 0; i < 5; i++) x ^= oran5[(c*5+i)*4 +: 4];
          total++; if (x !== 4'h0) begin
            bad++; $display("FAIL rnd_xor_%0d_ch%0d got=%h want=0", n, c, x);
          end
        end
      end
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ring5(r5));
      lvl_m = lvl_m + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    v5 = 1'b0; rdy5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_shares();
    test_three_shares();
    test_ring();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
